// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU bus bundle for alu_issue_ctrl. slave = controller side,
// master = decode/ALU/regfile side.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int OP_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_rd;
    logic             in_setf;
    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_nzcv;
    logic             wb_valid;
    logic             wb_ready;
    logic [2:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       flags;
    logic             busy;
    logic             illegal;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, in_setf, alu_result, alu_nzcv, wb_ready,
        output in_ready, alu_op, alu_a, alu_b, wb_valid, wb_rd, wb_data, flags, busy, illegal
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, in_setf, alu_result, alu_nzcv, wb_ready,
        input  in_ready, alu_op, alu_a, alu_b, wb_valid, wb_rd, wb_data, flags, busy, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end of the 16-bit ALU: accepts ops, waits per-op latency,
// captures result and flags, presents writeback. Optional feature macro: ALU_BYPASS_EN.
module alu_issue_ctrl #(
    parameter int WIDTH   = 16,
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
    localparam logic [OP_W-1:0] OP_CMP = OP_W'(4);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(7);
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SHL = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SHR = OP_W'(10);

    localparam int LAT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [OP_W-1:0]  op_q,      op_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [2:0]       rd_q,      rd_d;
    logic             setf_q,    setf_d;
    logic             div0_q,    div0_d;
    logic [2:0]       wb_rd_q,   wb_rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [3:0]       flags_q,   flags_d;
    logic             illegal_q, illegal_d;
    logic             in_ready_s;
    logic             accept_s;
    logic             in_b_zero_s;
    logic [3:0]       flags_cap_s;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP,
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: is_legal = 1'b1;
            default:                                       is_legal = 1'b0;
        endcase
    endfunction

    // Remaining EXEC cycles after the first; a divide by zero never waits on the ALU.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [OP_W-1:0] op, input logic b_zero);
        case (op)
            OP_MUL:  lat_m1 = CNT_W'(MUL_LAT - 1);
            OP_DIV:  lat_m1 = b_zero ? {CNT_W{1'b0}} : CNT_W'(DIV_LAT - 1);
            default: lat_m1 = {CNT_W{1'b0}};
        endcase
    endfunction

`ifdef ALU_BYPASS_EN
    assign in_ready_s = (state_q == S_IDLE) | ((state_q == S_WB) & bus.wb_ready);
`else
    assign in_ready_s = (state_q == S_IDLE);
`endif
    assign accept_s    = bus.in_valid & in_ready_s;
    assign in_b_zero_s = (bus.in_b == {WIDTH{1'b0}});

    // Flag value loaded when an op completes; logic/shift ops keep C and V.
    always_comb begin
        case (op_q)
            OP_CMP:                         flags_cap_s = bus.alu_nzcv;
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: flags_cap_s = setf_q ? (div0_q ? 4'b1001 : bus.alu_nzcv) : flags_q;
            OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR:                 flags_cap_s = setf_q ? {bus.alu_nzcv[3:2], flags_q[1:0]} : flags_q;
            default:                        flags_cap_s = flags_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        setf_d    = setf_q;
        div0_d    = div0_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        flags_d   = flags_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_EXEC: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!is_legal(op_q) || (op_q == OP_CMP)) begin
                    flags_d = flags_cap_s;
                    state_d = S_IDLE;
                end else begin
                    flags_d   = flags_cap_s;
                    wb_rd_d   = rd_q;
                    wb_data_d = div0_q ? {WIDTH{1'b1}} : bus.alu_result;
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                if (bus.wb_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Accept overrides whichever state the case chose (IDLE, or WB under bypass).
        if (accept_s) begin
            state_d   = S_EXEC;
            op_d      = bus.in_op;
            a_d       = bus.in_a;
            b_d       = bus.in_b;
            rd_d      = bus.in_rd;
            setf_d    = bus.in_setf;
            div0_d    = (bus.in_op == OP_DIV) && in_b_zero_s;
            cnt_d     = lat_m1(bus.in_op, in_b_zero_s);
            illegal_d = !is_legal(bus.in_op);
        end else begin
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            op_q      <= {OP_W{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            rd_q      <= 3'd0;
            setf_q    <= 1'b0;
            div0_q    <= 1'b0;
            wb_rd_q   <= 3'd0;
            wb_data_q <= {WIDTH{1'b0}};
            flags_q   <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            setf_q    <= setf_d;
            div0_q    <= div0_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.alu_op   = op_q;
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.wb_valid = (state_q == S_WB);
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.flags    = flags_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl (default build): a latency-aware ALU model
// plus a transaction-level reference for timing, writeback data and flags.
module tb_alu_issue_ctrl;
    localparam int WIDTH   = 16;
    localparam int OP_W    = 5;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 16;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_CMP = 5'd4;
    localparam logic [4:0] OP_AND = 5'd5;
    localparam logic [4:0] OP_OR  = 5'd6;
    localparam logic [4:0] OP_XOR = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8;
    localparam logic [4:0] OP_SHL = 5'd9;
    localparam logic [4:0] OP_SHR = 5'd10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         exec_start = 0;
    logic [3:0] model_flags = 4'd0;
    logic [19:0] alu_out;

    alu_issue_ctrl_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus();

    alu_issue_ctrl #(.WIDTH(WIDTH), .OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {N,Z,C,V,result}.
    function automatic logic [19:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        logic [31:0] p;
        logic [15:0] r;
        logic c, v;
        t = 17'd0; p = 32'd0; r = 16'd0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            OP_SUB, OP_CMP: begin
                t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = ~t[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            OP_MUL: begin p = a * b; r = p[15:0]; c = |p[31:16]; end
            OP_DIV: r = (b == 16'd0) ? 16'd0 : a / b;
            OP_AND: begin r = a & b;      c = a[15]; v = a[0]; end
            OP_OR:  begin r = a | b;      c = a[15]; v = a[0]; end
            OP_XOR: begin r = a ^ b;      c = a[15]; v = a[0]; end
            OP_NOT: begin r = ~a;         c = a[15]; v = a[0]; end
            OP_SHL: begin r = a << b[3:0]; c = a[15]; v = a[0]; end
            OP_SHR: begin r = a >> b[3:0]; c = a[15]; v = a[0]; end
            default: begin r = 16'hDEAD; c = 1'b1; v = 1'b1; end
        endcase
        return {r[15], (r == 16'd0), c, v, r};
    endfunction

    function automatic int alu_lat(input logic [4:0] op);
        if (op == OP_MUL) return MUL_LAT;
        else if (op == OP_DIV) return DIV_LAT;
        else return 1;
    endfunction

    // The external ALU only presents a correct result once its latency has elapsed.
    always_comb begin
        alu_out = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
        if ((cyc - exec_start) >= alu_lat(bus.alu_op)) begin
            bus.alu_result = alu_out[15:0];
            bus.alu_nzcv   = alu_out[19:16];
        end else begin
            bus.alu_result = ~alu_out[15:0];
            bus.alu_nzcv   = ~alu_out[19:16];
        end
    end

    task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] rd, input logic setf, input int stall);
        int         waitc, lat;
        logic       legal, has_wb, div0, bad;
        logic [19:0] ref_out;
        logic [15:0] exp_data;
        logic [3:0] nz, exp_flags;
        waitc = 0;
        while (bus.in_ready !== 1'b1 && waitc < 50) begin
            @(posedge clk); #1; waitc++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        legal    = (op <= OP_SHR);
        has_wb   = legal && (op != OP_CMP);
        div0     = (op == OP_DIV) && (b == 16'd0);
        lat      = div0 ? 1 : alu_lat(op);
        ref_out  = alu_f(op, a, b);
        nz       = ref_out[19:16];
        exp_data = div0 ? 16'hFFFF : ref_out[15:0];
        exp_flags = model_flags;
        if (!legal) exp_flags = model_flags;
        else if (op == OP_CMP) exp_flags = nz;
        else if (op <= OP_DIV) exp_flags = setf ? (div0 ? 4'b1001 : nz) : model_flags;
        else exp_flags = setf ? {nz[3:2], model_flags[1:0]} : model_flags;

        bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
        bus.in_rd = rd; bus.in_setf = setf; bus.wb_ready = (stall == 0);
        exec_start = cyc;
        @(posedge clk); #1;
        // Junk offered while busy must be ignored.
        bus.in_op = 5'($urandom); bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);
        bus.in_rd = 3'($urandom); bus.in_setf = 1'($urandom);
        checks++;
        if (bus.illegal !== !legal) begin
            failures++; $display("FAIL illegal_pulse op=%0d: got %b required %b", op, bus.illegal, !legal);
        end
        bad = 1'b0;
        for (int c = 0; c < lat; c++) begin
            if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.alu_op !== op || bus.alu_a !== a || bus.alu_b !== b) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL exec_phase op=%0d: wb_valid/busy/in_ready/alu_* wrong during EXEC, required 0/1/0/issued", op);
        end
        if (has_wb) begin
            checks++;
            if (bus.wb_valid !== 1'b1) begin
                failures++; $display("FAIL wb_valid_timing op=%0d: got %b required 1 at k+%0d", op, bus.wb_valid, lat + 1);
            end
            checks++;
            if (bus.wb_data !== exp_data) begin
                failures++; $display("FAIL wb_data op=%0d a=%h b=%h: got %h required %h", op, a, b, bus.wb_data, exp_data);
            end
            checks++;
            if (bus.wb_rd !== rd) begin
                failures++; $display("FAIL wb_rd op=%0d: got %0d required %0d", op, bus.wb_rd, rd);
            end
            bad = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp_data || bus.wb_rd !== rd ||
                    bus.in_ready !== 1'b0) bad = 1'b1;
            end
            if (stall > 0) begin
                checks++;
                if (bad) begin
                    failures++; $display("FAIL wb_hold op=%0d: writeback not stable under wb_ready=0 for %0d cycles", op, stall);
                end
            end
            bus.wb_ready = 1'b1;
            @(posedge clk); #1;
        end else begin
            checks++;
            if (bus.wb_valid !== 1'b0 || bus.illegal !== 1'b0) begin
                failures++; $display("FAIL no_wb op=%0d: wb_valid=%b illegal=%b required 0 0", op, bus.wb_valid, bus.illegal);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
            failures++; $display("FAIL back_to_idle op=%0d: in_ready=%b busy=%b wb_valid=%b required 1 0 0",
                                 op, bus.in_ready, bus.busy, bus.wb_valid);
        end
        checks++;
        if (bus.flags !== exp_flags) begin
            failures++; $display("FAIL flags op=%0d setf=%b: got %b required %b", op, setf, bus.flags, exp_flags);
        end
        model_flags = exp_flags;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_a = 16'h1111; bus.in_b = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.wb_valid, bus.illegal, bus.flags, bus.wb_rd} !== 9'd0) begin
            failures++; $display("FAIL reset_ctrl: busy/wb_valid/illegal/flags/wb_rd=%b required 0",
                                 {bus.busy, bus.wb_valid, bus.illegal, bus.flags, bus.wb_rd});
        end
        checks++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.wb_data} !== 69'd0) begin
            failures++; $display("FAIL reset_data: alu_op=%h alu_a=%h alu_b=%h wb_data=%h required 0",
                                 bus.alu_op, bus.alu_a, bus.alu_b, bus.wb_data);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle: in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy);
        end
        model_flags = 4'd0;
    endtask

    task automatic test_directed();
        run_op(OP_ADD, 16'h7FFF, 16'h0001, 3'd1, 1'b1, 0);
        run_op(OP_MUL, 16'd300, 16'd300, 3'd2, 1'b0, 0);
        run_op(OP_CMP, 16'd5, 16'd5, 3'd3, 1'b0, 0);
        run_op(OP_DIV, 16'd100, 16'd0, 3'd4, 1'b1, 0);
        run_op(OP_ADD, 16'h1234, 16'h0101, 3'd5, 1'b0, 5);
        run_op(OP_DIV, 16'd1000, 16'd7, 3'd6, 1'b1, 1);
        run_op(OP_XOR, 16'h8000, 16'h0000, 3'd7, 1'b1, 0);
    endtask

    task automatic test_illegal();
        run_op(5'd20, 16'hAAAA, 16'h5555, 3'd2, 1'b1, 0);
        run_op(5'd31, 16'h0000, 16'h0000, 3'd0, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [15:0] b;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(11, 31));
            else op = 5'($urandom_range(0, 10));
            b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            run_op(op, 16'($urandom), b, 3'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_op();
        logic bad;
        run_op(OP_ADD, 16'h7FFF, 16'h0001, 3'd1, 1'b1, 0);
        bus.in_valid = 1'b1; bus.in_op = OP_DIV; bus.in_a = 16'd1234; bus.in_b = 16'd7;
        bus.in_rd = 3'd5; bus.in_setf = 1'b1; bus.wb_ready = 1'b1;
        exec_start = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        checks++;
        if (bus.busy !== 1'b1 || bus.wb_valid !== 1'b0) begin
            failures++; $display("FAIL div_in_exec: busy=%b wb_valid=%b required 1 0", bus.busy, bus.wb_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0 || bus.flags !== 4'd0) begin
            failures++; $display("FAIL reset_mid_op: busy=%b wb_valid=%b flags=%b required 0 0 0000",
                                 bus.busy, bus.wb_valid, bus.flags);
        end
        rst_n = 1'b1;
        model_flags = 4'd0;
        bad = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.wb_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL abandoned_wb: wb_valid rose after reset, required never");
        end
        run_op(OP_SUB, 16'd3, 16'd9, 3'd2, 1'b1, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = 5'd0; bus.in_a = 16'd0; bus.in_b = 16'd0;
        bus.in_rd = 3'd0; bus.in_setf = 1'b0; bus.wb_ready = 1'b1;
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
